// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
// One req/ack transaction per access. Write data and byte enables are big-endian lanes.
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through and runs a req/ack bus cycle for loads and stores.
// Optional feature macro MEM_ALIGN_EXC_EN: misaligned accesses raise mem_adel/mem_ades instead of using the bus.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_we,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_waddr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stallreq,
  output logic        mem_adel,
  output logic        mem_ades,
  mem_stage_if.master bus
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load, is_store, acc_byte, acc_half, acc_word, ld_signed;
  logic        align_err, mem_go;
  logic [3:0]  sel_calc;
  logic [31:0] st_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_result;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    acc_byte  = 1'b0;
    acc_half  = 1'b0;
    acc_word  = 1'b0;
    ld_signed = 1'b0;
    case (ex_aluop)
      EXE_LB_OP:  begin is_load  = 1'b1; acc_byte = 1'b1; ld_signed = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; acc_byte = 1'b1; end
      EXE_LH_OP:  begin is_load  = 1'b1; acc_half = 1'b1; ld_signed = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; acc_half = 1'b1; end
      EXE_LW_OP:  begin is_load  = 1'b1; acc_word = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; acc_byte = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; acc_half = 1'b1; end
      EXE_SW_OP:  begin is_store = 1'b1; acc_word = 1'b1; end
      default:    ;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  assign align_err = (acc_half && ex_mem_addr[0]) ||
                     (acc_word && (ex_mem_addr[1:0] != 2'b00));
  assign mem_adel  = is_load  && align_err;
  assign mem_ades  = is_store && align_err;
`else
  assign align_err = 1'b0;
  assign mem_adel  = 1'b0;
  assign mem_ades  = 1'b0;
`endif

  assign mem_go = (is_load || is_store) && !align_err;

  // Big-endian lanes: address 0 of a word is the most significant byte.
  always_comb begin
    sel_calc = 4'b1111;
    st_data  = ex_reg2;
    if (acc_byte) begin
      st_data = {4{ex_reg2[7:0]}};
      case (ex_mem_addr[1:0])
        2'b00:   sel_calc = 4'b1000;
        2'b01:   sel_calc = 4'b0100;
        2'b10:   sel_calc = 4'b0010;
        default: sel_calc = 4'b0001;
      endcase
    end else if (acc_half) begin
      st_data  = {2{ex_reg2[15:0]}};
      sel_calc = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_go) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {ex_mem_addr[31:2], 2'b00};
          sel_d   = sel_calc;
          wdata_d = st_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.bus_ack) begin
          req_d = 1'b0;
          if (!we_q) begin
            rdata_d = bus.bus_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_wdata = wdata_q;

  // Reset also clears the stall so an abandoned access releases the pipeline at once.
  assign stallreq = rst && mem_go && (state_q != DONE);

  always_comb begin
    case (ex_mem_addr[1:0])
      2'b00:   lane_byte = rdata_q[31:24];
      2'b01:   lane_byte = rdata_q[23:16];
      2'b10:   lane_byte = rdata_q[15:8];
      default: lane_byte = rdata_q[7:0];
    endcase
    lane_half = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (acc_byte) begin
      load_result = {{24{ld_signed && lane_byte[7]}}, lane_byte};
    end else if (acc_half) begin
      load_result = {{16{ld_signed && lane_half[15]}}, lane_half};
    end else begin
      load_result = rdata_q;
    end
  end

  always_comb begin
    mem_waddr = ex_waddr;
    mem_we    = ex_we;
    mem_wdata = ex_wdata;
    mem_whilo = ex_whilo;
    mem_hi    = ex_hi;
    mem_lo    = ex_lo;
    if ((state_q == DONE) && is_load) begin
      mem_wdata = load_result;
    end
    if (stallreq) begin
      mem_we    = 1'b0;
      mem_whilo = 1'b0;
    end
    if (align_err) begin
      mem_we = 1'b0;
    end
  end

endmodule
